// File: rtl/sdram_wb_arbiter.sv
// Three-port Wishbone Classic arbiter in front of the single SDRAM controller slave port.
// m0 (video) has priority bounded by a run limiter; m1 (CPU) and m2 (DMA) share round-robin.
module sdram_wb_arbiter #(
   parameter int unsigned ADDR_W     = 24,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned M0_MAX_RUN = 4,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_adr_i,
   input  logic [DATA_W-1:0] m0_dat_i,
   input  logic [SEL_W-1:0]  m0_sel_i,
   output logic [DATA_W-1:0] m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_adr_i,
   input  logic [DATA_W-1:0] m1_dat_i,
   input  logic [SEL_W-1:0]  m1_sel_i,
   output logic [DATA_W-1:0] m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   input  logic              m2_cyc_i,
   input  logic              m2_stb_i,
   input  logic              m2_we_i,
   input  logic [ADDR_W-1:0] m2_adr_i,
   input  logic [DATA_W-1:0] m2_dat_i,
   input  logic [SEL_W-1:0]  m2_sel_i,
   output logic [DATA_W-1:0] m2_dat_o,
   output logic              m2_ack_o,
   output logic              m2_err_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [ADDR_W-1:0] s_adr_o,
   output logic [DATA_W-1:0] s_dat_o,
   output logic [SEL_W-1:0]  s_sel_o,
   input  logic [DATA_W-1:0] s_dat_i,
   input  logic              s_ack_i,
   output logic [1:0]        grant_o,
   output logic              busy_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam int unsigned RUN_W = $clog2(M0_MAX_RUN + 1);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e                   state_q;
   logic [CNT_W-1:0]         tmo_q;
   logic [RUN_W-1:0]         run_q;
   logic [1:0]               rr_last_q;
   logic                     abandon_q;
   logic [2:0]               ack_q;
   logic [2:0]               err_q;
   logic [2:0][DATA_W-1:0]   rdat_q;

   logic [2:0]               req;
   logic [1:0]               win;
   logic                     w_we;
   logic [ADDR_W-1:0]        w_adr;
   logic [DATA_W-1:0]        w_dat;
   logic [SEL_W-1:0]         w_sel;
   logic                     gnt_cyc;

   // m0 keeps winning until it has used its run budget while someone else waits.
   always_comb begin
      req = {m2_cyc_i & m2_stb_i, m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
      win = 2'd2;
      if (req[0] && ((run_q < RUN_W'(M0_MAX_RUN)) || !(req[1] || req[2]))) begin
         win = 2'd0;
      end else if (req[1] && (!req[2] || rr_last_q != 2'd1)) begin
         win = 2'd1;
      end
   end

   always_comb begin
      w_we  = m2_we_i;
      w_adr = m2_adr_i;
      w_dat = m2_dat_i;
      w_sel = m2_sel_i;
      case (win)
         2'd0: begin
            w_we  = m0_we_i;
            w_adr = m0_adr_i;
            w_dat = m0_dat_i;
            w_sel = m0_sel_i;
         end
         2'd1: begin
            w_we  = m1_we_i;
            w_adr = m1_adr_i;
            w_dat = m1_dat_i;
            w_sel = m1_sel_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (grant_o)
         2'd0:    gnt_cyc = m0_cyc_i;
         2'd1:    gnt_cyc = m1_cyc_i;
         2'd2:    gnt_cyc = m2_cyc_i;
         default: gnt_cyc = 1'b0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= StIdle;
         tmo_q     <= '0;
         run_q     <= '0;
         rr_last_q <= 2'd2;
         abandon_q <= 1'b0;
         ack_q     <= '0;
         err_q     <= '0;
         rdat_q    <= '0;
         s_cyc_o   <= 1'b0;
         s_stb_o   <= 1'b0;
         s_we_o    <= 1'b0;
         s_adr_o   <= '0;
         s_dat_o   <= '0;
         s_sel_o   <= '0;
         grant_o   <= 2'd3;
      end else begin
         ack_q <= '0;
         err_q <= '0;
         case (state_q)
            StIdle: begin
               if (|req) begin
                  s_cyc_o   <= 1'b1;
                  s_stb_o   <= 1'b1;
                  s_we_o    <= w_we;
                  s_adr_o   <= w_adr;
                  s_dat_o   <= w_dat;
                  s_sel_o   <= w_sel;
                  grant_o   <= win;
                  tmo_q     <= '0;
                  abandon_q <= 1'b0;
                  state_q   <= StBusy;
                  if (win == 2'd0) begin
                     if (run_q < RUN_W'(M0_MAX_RUN)) run_q <= run_q + 1'b1;
                  end else begin
                     run_q     <= '0;
                     rr_last_q <= win;
                  end
               end
            end
            StBusy: begin
               // A master that let go of cyc gets neither ack nor err for this transfer.
               if (s_ack_i) begin
                  s_cyc_o <= 1'b0;
                  s_stb_o <= 1'b0;
                  state_q <= StResp;
                  if (!abandon_q && gnt_cyc) begin
                     ack_q[grant_o] <= 1'b1;
                     if (!s_we_o) rdat_q[grant_o] <= s_dat_i;
                  end
               end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                  s_cyc_o <= 1'b0;
                  s_stb_o <= 1'b0;
                  grant_o <= 2'd3;
                  state_q <= StIdle;
                  if (!abandon_q && gnt_cyc) err_q[grant_o] <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
                  if (!gnt_cyc) abandon_q <= 1'b1;
               end
            end
            StResp: begin
               grant_o <= 2'd3;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign m0_ack_o = ack_q[0];
   assign m1_ack_o = ack_q[1];
   assign m2_ack_o = ack_q[2];
   assign m0_err_o = err_q[0];
   assign m1_err_o = err_q[1];
   assign m2_err_o = err_q[2];
   assign m0_dat_o = rdat_q[0];
   assign m1_dat_o = rdat_q[1];
   assign m2_dat_o = rdat_q[2];
   assign busy_o   = (state_q != StIdle);

endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
Three-port Wishbone Classic arbiter that shares the single SDRAM controller slave port between video fetch (m0), CPU (m1) and DMA (m2). m0 has fixed priority, bounded by a starvation limiter. m1 and m2 are served round-robin. The arbiter registers each transfer toward the slave and inserts a mandatory idle cycle between transfers, so the downstream controller never sees back-to-back strobes.

Parameters:
ADDR_W, 24, Wishbone address width
DATA_W, 16, Wishbone data width
SEL_W, 2, byte-select width (DATA_W/8)
M0_MAX_RUN, 4, consecutive m0 grants allowed while m1/m2 are waiting
TIMEOUT, 1023, cycles in BUSY without s_ack before the transfer is aborted

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous reset, active-high
mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  master N (N=0,1,2) cycle, strobe, write enable
mN_adr_i  in  ADDR_W  master N address
mN_dat_i  in  DATA_W  master N write data
mN_sel_i  in  SEL_W  master N byte select
mN_dat_o  out  DATA_W  master N read data
mN_ack_o, mN_err_o  out  1 each  master N acknowledge, error
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable
s_adr_o  out  ADDR_W  slave address
s_dat_o  out  DATA_W  slave write data
s_sel_o  out  SEL_W  slave byte select
s_dat_i  in  DATA_W  slave read data
s_ack_i  in  1  slave acknowledge
grant_o  out  2  active grant: 0/1/2, 3=none (debug)
busy_o  out  1  state != IDLE

Behaviour:
- Reset (synchronous): state=IDLE; all ack/err/cyc/stb/we outputs 0; all dat_o, s_adr_o, s_dat_o 0; s_sel_o 0; grant_o=3; rr_last=2; m0_run=0; timeout counter 0.
- Request: reqN = mN_cyc_i & mN_stb_i.
- IDLE, arbitration evaluated every cycle:
  - If req0 and (m0_run < M0_MAX_RUN, or neither req1 nor req2): grant m0, m0_run++ (saturating).
  - Else grant round-robin between m1 and m2, starting after rr_last. Set rr_last to the winner and clear m0_run.
  - A grant to m1/m2 while req0 is low also clears m0_run.
  - On grant: latch we/adr/dat/sel of the winner into the s_* registers, set s_cyc_o=s_stb_o=1, set grant_o, go to BUSY. s_stb_o is therefore high in the cycle after the request is first seen (1-cycle arbitration latency).
- BUSY: s_* outputs held stable. Timeout counter increments each cycle.
  - On s_ack_i: capture s_dat_i (reads only; write data_o is unchanged), drop s_cyc_o/s_stb_o, go to RESP.
  - If counter reaches TIMEOUT with no ack: drop s_cyc_o/s_stb_o, pulse mN_err_o for one cycle, go to IDLE.
- RESP (1 cycle): mN_ack_o=1 for the granted master only, mN_dat_o valid. Slave strobe is low, which provides the idle gap. Next state IDLE, grant_o=3.
- Total latency, request to master ack = controller ack latency + 2 cycles.
- Master abandon: if the granted master drops cyc during BUSY, the arbiter still holds the slave transfer until s_ack_i (the controller has already latched it). The response is discarded: no ack, no dat_o update.
- A stray s_ack_i in IDLE or RESP is ignored.
- Reset asserted mid-transfer forces IDLE next cycle with all strobes low. The controller reset is shared, so no drain is needed.
- ack and err are never both asserted. Only one master sees ack or err per transfer.
- mN_dat_o holds its last read value until the next read completes for that master.

Test Plan:
- Single m1 read at 0x012345, controller acks after 8 cycles returning 0xBEEF -> s_stb_o high 1 cycle after request; m1_ack_o exactly one cycle with m1_dat_o=0xBEEF; m0/m2 ack stay 0.
- m0, m1, m2 request continuously, M0_MAX_RUN=4 -> grant sequence 0,0,0,0,1,0,0,0,0,2,0,…; s_stb_o low at least one cycle between every grant.
- m1 and m2 only, 6 back-to-back transfers each -> strict alternation 1,2,1,2…; neither master waits more than one foreign transfer.
- m2 write 0xA5A5, sel=2'b01 at 0x000200 -> s_we_o=1, s_dat_o=0xA5A5, s_sel_o=01, all stable from stb rise until s_ack_i; m2_ack_o one cycle later.
- Slave never acks, TIMEOUT=16 -> m1_err_o pulses at cycle 16 of BUSY; s_cyc_o low; arbiter returns to IDLE and serves a pending m2 next.
- m0 drops cyc two cycles into BUSY; assert reset during a later transfer -> no m0_ack_o for the abandoned transfer; after reset all outputs 0 and grant_o=3 on the next cycle.
